// File: rtl/mux_n_to_1_rr_stream.sv
// N-channel streaming multiplexer with valid/ready handshakes and one registered output stage.
// Grants come either from the external select or from a round-robin pointer.
module mux_n_to_1_rr_stream #(
   parameter int N  = 9,
   parameter int W  = 8,
   parameter int M  = (N > 1) ? $clog2(N) : 1,
   parameter int RR = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   input  logic [M-1:0]   sel,
   output logic [W-1:0]   out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [M-1:0]   out_chan
);

   logic [M-1:0] ptr;
   logic [M-1:0] gnt;
   logic         gnt_ok;
   logic         load;
   logic [M:0]   rr_result;
   logic         fixed_ok;

   // Scans from the highest offset down so the lowest offset from the pointer wins.
   function automatic logic [M:0] rr_pick(input logic [N-1:0] valid, input logic [M-1:0] start);
      int           idx;
      logic [M-1:0] chan;
      rr_pick = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(start) + k;
         if (idx >= N) idx = idx - N;
         chan = M'(idx);
         if (valid[chan]) rr_pick = {1'b1, chan};
      end
   endfunction

   assign load      = !out_valid || out_ready;
   assign rr_result = rr_pick(in_valid, ptr);
   assign fixed_ok  = (int'(sel) < N) ? in_valid[sel] : 1'b0;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      gnt      = '0;
      gnt_ok   = 1'b0;
      in_ready = '0;
      if (RR != 0) begin
         gnt    = rr_result[M-1:0];
         gnt_ok = rr_result[M];
      end else begin
         gnt    = sel;
         gnt_ok = fixed_ok;
      end
      if (rst_n && load && gnt_ok) in_ready[gnt] = 1'b1;
   end

   // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
   // NOTE: out_data is reset too, because the consumer may observe it while out_valid is low.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (gnt_ok) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gnt)*W +: W];
            out_chan  <= gnt;
            if (RR != 0) ptr <= (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_n_to_1_rr_stream.sv
// Bench for mux_n_to_1_rr_stream: a round-robin instance and a fixed-select instance share stimulus
// and are compared every cycle against a behavioural model of the handshake rules.
module tb_mux_n_to_1_rr_stream;

   localparam int N = 9;
   localparam int W = 8;
   localparam int M = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N*W-1:0] in_data = '0;
   logic [N-1:0]   in_valid = '0;
   logic           out_ready = 1'b0;
   logic [M-1:0]   sel = '0;
   logic [M-1:0]   rr_sel = '0;

   logic [N-1:0]   rr_in_ready, fs_in_ready;
   logic [W-1:0]   rr_out_data, fs_out_data;
   logic           rr_out_valid, fs_out_valid;
   logic [M-1:0]   rr_out_chan, fs_out_chan;

   int total = 0;
   int bad = 0;

   // Model state, index 0 = round-robin instance, index 1 = fixed-select instance.
   logic           m_valid[2];
   logic [W-1:0]   m_data[2];
   int             m_chan[2];
   int             m_ptr;

   always #5 clk = ~clk;

   mux_n_to_1_rr_stream #(.N(N), .W(W), .M(M), .RR(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rr_in_ready),
      .sel(rr_sel), .out_data(rr_out_data), .out_valid(rr_out_valid), .out_ready(out_ready),
      .out_chan(rr_out_chan));

   mux_n_to_1_rr_stream #(.N(N), .W(W), .M(M), .RR(0)) u_fs (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(fs_in_ready),
      .sel(sel), .out_data(fs_out_data), .out_valid(fs_out_valid), .out_ready(out_ready),
      .out_chan(fs_out_chan));

   function automatic logic [N*W-1:0] rand_data();
      logic [N*W-1:0] d;
      for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
      return d;
   endfunction

   // One clock: drive at the falling edge, check in_ready, advance the model, check the outputs.
   task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] dat, input logic ordy,
                       input logic [M-1:0] s, input string tag);
      logic         load, ok;
      int           g;
      logic [N-1:0] exp_rdy, got_rdy;
      logic         got_valid;
      logic [W-1:0] got_data;
      logic [M-1:0] got_chan;
      @(negedge clk);
      in_valid  = v;
      in_data   = dat;
      out_ready = ordy;
      sel       = s;
      #1;
      for (int d = 0; d < 2; d++) begin
         load = !m_valid[d] || ordy;
         ok   = 1'b0;
         g    = 0;
         if (d == 0) begin
            for (int k = N - 1; k >= 0; k--)
               if (v[(m_ptr + k) % N]) begin ok = 1'b1; g = (m_ptr + k) % N; end
         end else if (int'(s) < N) begin
            ok = v[int'(s)];
            g  = int'(s);
         end
         exp_rdy = (rst_n && load && ok) ? (N'(1) << g) : '0;
         got_rdy = (d == 0) ? rr_in_ready : fs_in_ready;
         total++;
         if (got_rdy !== exp_rdy) begin
            bad++;
            $display("FAIL %s/%s in_ready: got %b expected %b", tag, d == 0 ? "rr" : "fs", got_rdy, exp_rdy);
         end
         if (!rst_n) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_chan[d]  = 0;
            if (d == 0) m_ptr = 0;
         end else if (load) begin
            if (ok) begin
               m_valid[d] = 1'b1;
               m_data[d]  = dat[g*W +: W];
               m_chan[d]  = g;
               if (d == 0) m_ptr = (g + 1) % N;
            end else begin
               m_valid[d] = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         got_valid = (d == 0) ? rr_out_valid : fs_out_valid;
         got_data  = (d == 0) ? rr_out_data  : fs_out_data;
         got_chan  = (d == 0) ? rr_out_chan  : fs_out_chan;
         total += 3;
         if (got_valid !== m_valid[d]) begin
            bad++;
            $display("FAIL %s/%s out_valid: got %b expected %b", tag, d == 0 ? "rr" : "fs", got_valid, m_valid[d]);
         end
         if (got_data !== m_data[d]) begin
            bad++;
            $display("FAIL %s/%s out_data: got %h expected %h", tag, d == 0 ? "rr" : "fs", got_data, m_data[d]);
         end
         if (got_chan !== M'(m_chan[d])) begin
            bad++;
            $display("FAIL %s/%s out_chan: got %0d expected %0d", tag, d == 0 ? "rr" : "fs", got_chan, m_chan[d]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step('1, rand_data(), 1'b1, 4'd0, "reset");
      step('1, rand_data(), 1'b1, 4'd0, "reset");
      total++;
      if (rr_out_valid !== 1'b0 || rr_out_data !== '0 || rr_out_chan !== '0) begin
         bad++;
         $display("FAIL reset_state: got v=%b d=%h c=%0d expected 0/00/0", rr_out_valid, rr_out_data, rr_out_chan);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_rr_fairness();
      for (int i = 0; i < 18; i++) begin
         step('1, rand_data(), 1'b1, 4'd0, "fair");
         total++;
         if (rr_out_valid !== 1'b1 || int'(rr_out_chan) != i % 9) begin
            bad++;
            $display("FAIL fair_seq[%0d]: got chan %0d valid %b expected chan %0d valid 1", i, rr_out_chan, rr_out_valid, i % 9);
         end
      end
   endtask

   task automatic test_rr_wrap();
      int exp_seq[4] = '{2, 8, 2, 8};
      for (int i = 0; i < 4; i++) begin
         step((i == 0) ? 9'b0_0000_0100 : 9'b1_0000_0100, rand_data(), 1'b1, 4'd0, "wrap");
         total++;
         if (int'(rr_out_chan) != exp_seq[i]) begin
            bad++;
            $display("FAIL wrap_seq[%0d]: got chan %0d expected %0d", i, rr_out_chan, exp_seq[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [N*W-1:0] d;
      d = rand_data();
      d[4*W +: W] = 8'hA5;
      step(9'b0_0001_0000, d, 1'b1, 4'd4, "bp_load");
      for (int i = 0; i < 5; i++) begin
         step('1, rand_data(), 1'b0, 4'd4, "bp_stall");
         total++;
         if (rr_out_data !== 8'hA5 || rr_out_chan !== 4'd4 || rr_in_ready !== '0) begin
            bad++;
            $display("FAIL bp_hold[%0d]: got d=%h c=%0d rdy=%b expected A5/4/0", i, rr_out_data, rr_out_chan, rr_in_ready);
         end
      end
      step('0, rand_data(), 1'b1, 4'd4, "bp_drain");
      step('1, rand_data(), 1'b1, 4'd4, "bp_next");
      total++;
      if (rr_out_chan !== 4'd5) begin
         bad++;
         $display("FAIL bp_ptr: got chan %0d expected 5", rr_out_chan);
      end
   endtask

   task automatic test_fixed_select();
      logic [N*W-1:0] d;
      d = rand_data();
      step(N'($urandom) | 9'b0_0100_0000, d, 1'b1, 4'd6, "sel6");
      total++;
      if (fs_out_chan !== 4'd6 || fs_out_data !== d[6*W +: W] || fs_out_valid !== 1'b1) begin
         bad++;
         $display("FAIL sel6: got c=%0d d=%h v=%b expected 6/%h/1", fs_out_chan, fs_out_data, fs_out_valid, d[6*W +: W]);
      end
      step('1, rand_data(), 1'b1, 4'd10, "sel10");
      total++;
      if (fs_out_valid !== 1'b0 || fs_in_ready !== '0) begin
         bad++;
         $display("FAIL sel10: got v=%b rdy=%b expected 0/0", fs_out_valid, fs_in_ready);
      end
   endtask

   task automatic test_reset_mid();
      step(9'b0_0010_0000, rand_data(), 1'b1, 4'd5, "rm_load");
      step('1, rand_data(), 1'b0, 4'd5, "rm_stall");
      rst_n = 1'b0;
      step('1, rand_data(), 1'b0, 4'd5, "rm_reset");
      total++;
      if (rr_out_valid !== 1'b0 || fs_out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rm_discard: got rr=%b fs=%b expected 0/0", rr_out_valid, fs_out_valid);
      end
      rst_n = 1'b1;
      step(9'b0_1000_1000, rand_data(), 1'b1, 4'd3, "rm_first");
      total++;
      if (rr_out_chan !== 4'd3) begin
         bad++;
         $display("FAIL rm_first: got chan %0d expected 3", rr_out_chan);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++)
         step(N'($urandom), rand_data(), 1'($urandom_range(0, 3) != 0), M'($urandom_range(0, 15)), "rand");
   endtask

   initial begin
      m_valid = '{1'b0, 1'b0};
      m_data  = '{8'h00, 8'h00};
      m_chan  = '{0, 0};
      m_ptr   = 0;
      test_reset();
      test_rr_fairness();
      test_rr_wrap();
      test_backpressure();
      test_fixed_select();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
